uart_cmd_dispatcher: RTL and testbench
======================================

Name: uart_cmd_dispatcher

Overview:
Sits directly downstream of the 16-bit UART receiver and upstream of its transmitter. It consumes each received command word, validates it, and requests one sensor read from the sensor interface. It then builds a 16-bit response word and hands it to the transmitter through the transmitter's enable/finish handshake. It also runs an optional continuous-monitoring mode that re-reads one sensor periodically and streams the results.

Parameters:
NUM_SENSORS, 32, number of valid sensor addresses (0..NUM_SENSORS-1)
TIMEOUT_CYCLES, 9600, cycles to wait on sensor_done or a finish_transmission edge before aborting (1 s at 9600 Hz)
CONT_PERIOD, 19200, idle cycles between continuous-mode reads

Ports:
clk_9k6  in  1  system clock (baud-rate clock); all logic on rising edge
rst_n  in  1  synchronous reset, active-low
data_recevied  in  16  received word: [15:8] command, [7:0] sensor address
data_ready_to_read  in  1  receiver word valid (level); acted on at rising edge only
finish_transmission  in  1  transmitter done (level); acted on at rising edge only
data_to_send  out  16  response word: [15:8] response code, [7:0] payload
enable_transmiter  out  1  one-cycle start pulse to the transmitter
sensor_req  out  1  one-cycle read request
sensor_addr  out  8  address for the current request
sensor_done  in  1  sensor result valid (one-cycle pulse)
sensor_error  in  1  qualified by sensor_done; sensor fault
sensor_temp  in  8  temperature, valid with sensor_done
sensor_hum  in  8  humidity, valid with sensor_done
overrun  out  1  sticky; a command was dropped

Behaviour:
- Reset (rst_n=0 at clock edge):
  - all outputs 0; FSM to IDLE
  - pending buffer empty; continuous mode OFF; timers cleared
  - edge-detect registers loaded with 0
  - reset mid-operation aborts with no further transmit.
- Rising edges are detected against a registered copy of each input.
- Rx edge at cycle N: data_recevied is written into a 1-entry pending buffer.
  - Buffer already full: word dropped, overrun set; overrun clears only on reset.
- FSM states: IDLE, DECODE, SENSOR_REQ, SENSOR_WAIT, LOAD_TX, TX_WAIT.
- IDLE:
  - pending full -> DECODE; buffer freed.
  - Else if continuous mode is on and the period timer reaches CONT_PERIOD-1 -> SENSOR_REQ using the continuous address/kind.
  - Period timer counts only in IDLE and resets on leaving IDLE.
  - A pending command wins over a continuous tick in the same cycle.
- DECODE: command table, then address check, evaluated in this order:
  - Command not in 0x00..0x06 -> response FF_00.
  - Otherwise address >= NUM_SENSORS -> FE_00.
  - 0x00 status, 0x01 temp, 0x02 hum -> SENSOR_REQ.
  - 0x03 / 0x04: set continuous mode TEMP / HUM with the given address (replaces any active mode) -> SENSOR_REQ; the first result is sent immediately.
  - 0x05 / 0x06: if that mode is active, clear it -> response 0A_00 / 0B_00; otherwise -> FF_00.
  - Every non-read outcome goes to LOAD_TX.
- Latency: rx edge at N -> DECODE at N+1 -> sensor_req high at N+2, or enable_transmiter at N+2 for error/cancel responses.
- SENSOR_REQ: sensor_req=1 for one cycle, sensor_addr held stable until the sensor completes -> SENSOR_WAIT.
- SENSOR_WAIT, on sensor_done:
  - sensor_error=1 -> 1E_00
  - status request -> 1F_00
  - temp -> 09_<sensor_temp>
  - hum -> 08_<sensor_hum>
  - No sensor_done within TIMEOUT_CYCLES -> FD_00; continuous mode is also cleared.
  - sensor_done outside SENSOR_WAIT is ignored.
- LOAD_TX: data_to_send registered, enable_transmiter=1 for exactly one cycle -> TX_WAIT.
- TX_WAIT: data_to_send held stable.
  - finish_transmission rising edge -> IDLE.
  - No edge within TIMEOUT_CYCLES -> IDLE silently.
- Rx edges keep being captured in every state; at most one word is held.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - FSM state enum
  - command codes 0x00..0x06
  - response codes 1F, 1E, 09, 08, 0A, 0B, FF, FE, FD
  - continuous-mode enum {OFF, TEMP, HUM}
- One sub-module: uart_edge_detect (registered rising-edge pulse; instanced for rx ready and tx finish).
- Timeout and period counters stay inline.

Test Plan:
- Word 0x0103, sensor_done after 10 cycles with temp=0x19, error=0 -> sensor_req at N+2 with addr 0x03; data_to_send=0x0919; one enable pulse; IDLE after the finish edge.
- Word 0x0720 -> 0xFF00 at N+2, no sensor_req. Word 0x0120 with NUM_SENSORS=32 -> 0xFE00.
- Word 0x0002 with no sensor_done -> 0xFD00 after exactly TIMEOUT_CYCLES. Word 0x0002 with sensor_done+error -> 0x1E00.
- Word 0x0405, hum=0x30 -> 0x0830 immediately, then again every CONT_PERIOD idle cycles. Then word 0x0600 -> 0x0B00 with no further streaming. A second 0x0600 -> 0xFF00.
- Three rx edges during one SENSOR_WAIT -> second word processed after the current response; third dropped; overrun=1 and stays 1.
- rst_n=0 during TX_WAIT -> next cycle: all outputs 0, continuous OFF, pending buffer empty, overrun=0.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared definitions for the UART command dispatcher.
//               Holds the FSM state encoding, command and response codes,
//               the continuous-mode and read-kind enums, and a helper that
//               packs a response word.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_DECODE      = 3'd1;
  localparam logic [2:0] ST_SENSOR_REQ  = 3'd2;
  localparam logic [2:0] ST_SENSOR_WAIT = 3'd3;
  localparam logic [2:0] ST_LOAD_TX     = 3'd4;
  localparam logic [2:0] ST_TX_WAIT     = 3'd5;

  // Command codes (upper byte of the received word)
  localparam logic [7:0] CMD_STATUS    = 8'h00;
  localparam logic [7:0] CMD_TEMP      = 8'h01;
  localparam logic [7:0] CMD_HUM       = 8'h02;
  localparam logic [7:0] CMD_CONT_TEMP = 8'h03;
  localparam logic [7:0] CMD_CONT_HUM  = 8'h04;
  localparam logic [7:0] CMD_STOP_TEMP = 8'h05;
  localparam logic [7:0] CMD_STOP_HUM  = 8'h06;

  // Response codes (upper byte of the transmitted word)
  localparam logic [7:0] RSP_STATUS_OK = 8'h1F;
  localparam logic [7:0] RSP_SENS_ERR  = 8'h1E;
  localparam logic [7:0] RSP_TEMP      = 8'h09;
  localparam logic [7:0] RSP_HUM       = 8'h08;
  localparam logic [7:0] RSP_STOP_TEMP = 8'h0A;
  localparam logic [7:0] RSP_STOP_HUM  = 8'h0B;
  localparam logic [7:0] RSP_BAD_CMD   = 8'hFF;
  localparam logic [7:0] RSP_BAD_ADDR  = 8'hFE;
  localparam logic [7:0] RSP_TIMEOUT   = 8'hFD;

  typedef enum logic [1:0] {
    CONT_OFF  = 2'd0,
    CONT_TEMP = 2'd1,
    CONT_HUM  = 2'd2
  } cont_mode_e;

  typedef enum logic [1:0] {
    KIND_STATUS = 2'd0,
    KIND_TEMP   = 2'd1,
    KIND_HUM    = 2'd2
  } read_kind_e;

  function automatic logic [15:0] rsp_word(input logic [7:0] code,
                                           input logic [7:0] payload);
    return {code, payload};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : uart_edge_detect
// Description : Rising-edge detector. The input is compared against a
//               registered copy of itself; o_rise is high for the cycle in
//               which the input is 1 and its previous-cycle value was 0.
// Ports       : clk_9k6 - clock
//               rst_n   - synchronous active-low reset
//               i_sig   - level input
//               o_rise  - one-cycle rising-edge indication
// Revision    : 1.0 - initial release
// ============================================================================
module uart_edge_detect (
  input  logic clk_9k6,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk_9k6) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_dispatcher
// Description : Takes command words from the UART receiver, validates them,
//               issues one sensor read, and returns a 16-bit response to the
//               UART transmitter. Supports a continuous-monitoring mode that
//               periodically re-reads one sensor and streams the results.
// Ports       : clk_9k6             - baud-rate clock
//               rst_n               - synchronous active-low reset
//               data_recevied       - rx word [15:8] cmd, [7:0] address
//               data_ready_to_read  - rx valid level (rising edge used)
//               finish_transmission - tx done level (rising edge used)
//               data_to_send        - response word [15:8] code, [7:0] data
//               enable_transmiter   - one-cycle tx start pulse
//               sensor_req          - one-cycle sensor read request
//               sensor_addr         - sensor address of the current read
//               sensor_done         - sensor result strobe
//               sensor_error        - sensor fault (with sensor_done)
//               sensor_temp         - temperature (with sensor_done)
//               sensor_hum          - humidity (with sensor_done)
//               overrun             - sticky dropped-command flag
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_dispatcher
  import uart_cmd_pkg::*;
#(
  parameter int NUM_SENSORS    = 32,
  parameter int TIMEOUT_CYCLES = 9600,
  parameter int CONT_PERIOD    = 19200
) (
  input  logic        clk_9k6,
  input  logic        rst_n,
  input  logic [15:0] data_recevied,
  input  logic        data_ready_to_read,
  input  logic        finish_transmission,
  output logic [15:0] data_to_send,
  output logic        enable_transmiter,
  output logic        sensor_req,
  output logic [7:0]  sensor_addr,
  input  logic        sensor_done,
  input  logic        sensor_error,
  input  logic [7:0]  sensor_temp,
  input  logic [7:0]  sensor_hum,
  output logic        overrun
);

  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_PW = $clog2(CONT_PERIOD + 1);
  localparam logic [c_TW-1:0] c_TO_LAST  = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_PW-1:0] c_PER_LAST = c_PW'(CONT_PERIOD - 1);
  localparam logic [8:0]      c_NUM_SENS = 9'(NUM_SENSORS);

  logic             w_rx_rise;
  logic             w_fin_rise;
  logic             w_pend_take;
  logic [7:0]       w_cmd;
  logic [7:0]       w_addr;
  logic             w_addr_bad;

  logic [2:0]       r_state;
  logic             r_pend_valid;
  logic [15:0]      r_pend_data;
  logic [15:0]      r_cur;
  read_kind_e       r_kind;
  cont_mode_e       r_cont_mode;
  logic [7:0]       r_cont_addr;
  logic [7:0]       r_sensor_addr;
  logic [15:0]      r_tx_data;
  logic             r_overrun;
  logic [c_TW-1:0]  r_timer;
  logic [c_PW-1:0]  r_period;

  uart_edge_detect u_rx_edge (
    .clk_9k6 (clk_9k6),
    .rst_n   (rst_n),
    .i_sig   (data_ready_to_read),
    .o_rise  (w_rx_rise)
  );

  uart_edge_detect u_fin_edge (
    .clk_9k6 (clk_9k6),
    .rst_n   (rst_n),
    .i_sig   (finish_transmission),
    .o_rise  (w_fin_rise)
  );

  // IDLE empties the buffer this cycle, so a word arriving now still fits.
  assign w_pend_take = (r_state == ST_IDLE) && r_pend_valid;
  assign w_cmd       = r_cur[15:8];
  assign w_addr      = r_cur[7:0];
  assign w_addr_bad  = ({1'b0, w_addr} >= c_NUM_SENS);

  always_ff @(posedge clk_9k6) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pend_valid  <= 1'b0;
      r_pend_data   <= '0;
      r_cur         <= '0;
      r_kind        <= KIND_STATUS;
      r_cont_mode   <= CONT_OFF;
      r_cont_addr   <= '0;
      r_sensor_addr <= '0;
      r_tx_data     <= '0;
      r_overrun     <= 1'b0;
      r_timer       <= '0;
      r_period      <= '0;
    end else begin
      // One-entry pending buffer, filled in every FSM state
      if (w_rx_rise) begin
        if (r_pend_valid && !w_pend_take) begin
          r_overrun <= 1'b1;
        end else begin
          r_pend_valid <= 1'b1;
          r_pend_data  <= data_recevied;
        end
      end else if (w_pend_take) begin
        r_pend_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (r_pend_valid) begin
            r_cur    <= r_pend_data;
            r_period <= '0;
            r_state  <= ST_DECODE;
          end else if (r_cont_mode != CONT_OFF) begin
            if (r_period == c_PER_LAST) begin
              r_period      <= '0;
              r_kind        <= (r_cont_mode == CONT_TEMP) ? KIND_TEMP : KIND_HUM;
              r_sensor_addr <= r_cont_addr;
              r_state       <= ST_SENSOR_REQ;
            end else begin
              r_period <= r_period + c_PW'(1);
            end
          end else begin
            r_period <= '0;
          end
        end

        ST_DECODE: begin
          r_state <= ST_LOAD_TX;
          if (w_cmd > CMD_STOP_HUM) begin
            r_tx_data <= rsp_word(RSP_BAD_CMD, 8'h00);
          end else if (w_addr_bad) begin
            r_tx_data <= rsp_word(RSP_BAD_ADDR, 8'h00);
          end else begin
            case (w_cmd)
              CMD_STATUS: begin
                r_kind        <= KIND_STATUS;
                r_sensor_addr <= w_addr;
                r_state       <= ST_SENSOR_REQ;
              end
              CMD_TEMP: begin
                r_kind        <= KIND_TEMP;
                r_sensor_addr <= w_addr;
                r_state       <= ST_SENSOR_REQ;
              end
              CMD_HUM: begin
                r_kind        <= KIND_HUM;
                r_sensor_addr <= w_addr;
                r_state       <= ST_SENSOR_REQ;
              end
              CMD_CONT_TEMP: begin
                r_cont_mode   <= CONT_TEMP;
                r_cont_addr   <= w_addr;
                r_kind        <= KIND_TEMP;
                r_sensor_addr <= w_addr;
                r_state       <= ST_SENSOR_REQ;
              end
              CMD_CONT_HUM: begin
                r_cont_mode   <= CONT_HUM;
                r_cont_addr   <= w_addr;
                r_kind        <= KIND_HUM;
                r_sensor_addr <= w_addr;
                r_state       <= ST_SENSOR_REQ;
              end
              CMD_STOP_TEMP: begin
                if (r_cont_mode == CONT_TEMP) begin
                  r_cont_mode <= CONT_OFF;
                  r_tx_data   <= rsp_word(RSP_STOP_TEMP, 8'h00);
                end else begin
                  r_tx_data   <= rsp_word(RSP_BAD_CMD, 8'h00);
                end
              end
              CMD_STOP_HUM: begin
                if (r_cont_mode == CONT_HUM) begin
                  r_cont_mode <= CONT_OFF;
                  r_tx_data   <= rsp_word(RSP_STOP_HUM, 8'h00);
                end else begin
                  r_tx_data   <= rsp_word(RSP_BAD_CMD, 8'h00);
                end
              end
              default: r_tx_data <= rsp_word(RSP_BAD_CMD, 8'h00);
            endcase
          end
        end

        ST_SENSOR_REQ: begin
          r_timer <= '0;
          r_state <= ST_SENSOR_WAIT;
        end

        ST_SENSOR_WAIT: begin
          // A result arriving on the final timeout cycle still counts.
          if (sensor_done) begin
            r_timer <= '0;
            r_state <= ST_LOAD_TX;
            if (sensor_error) begin
              r_tx_data <= rsp_word(RSP_SENS_ERR, 8'h00);
            end else begin
              case (r_kind)
                KIND_TEMP: r_tx_data <= rsp_word(RSP_TEMP, sensor_temp);
                KIND_HUM:  r_tx_data <= rsp_word(RSP_HUM, sensor_hum);
                default:   r_tx_data <= rsp_word(RSP_STATUS_OK, 8'h00);
              endcase
            end
          end else if (r_timer == c_TO_LAST) begin
            r_timer     <= '0;
            r_cont_mode <= CONT_OFF;
            r_tx_data   <= rsp_word(RSP_TIMEOUT, 8'h00);
            r_state     <= ST_LOAD_TX;
          end else begin
            r_timer <= r_timer + c_TW'(1);
          end
        end

        ST_LOAD_TX: begin
          r_timer <= '0;
          r_state <= ST_TX_WAIT;
        end

        ST_TX_WAIT: begin
          if (w_fin_rise || (r_timer == c_TO_LAST)) begin
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + c_TW'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_to_send      = r_tx_data;
  assign enable_transmiter = (r_state == ST_LOAD_TX);
  assign sensor_req        = (r_state == ST_SENSOR_REQ);
  assign sensor_addr       = r_sensor_addr;
  assign overrun           = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_dispatcher
// Description : Directed self-checking bench for uart_cmd_dispatcher.
//               Inputs change and outputs are sampled on the falling edge.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_dispatcher;
  import uart_cmd_pkg::*;

  localparam int c_NUM = 32;
  localparam int c_TO  = 40;
  localparam int c_PER = 60;
  localparam int c_MAX = 400;

  logic        clk_9k6 = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_recevied = '0;
  logic        data_ready_to_read = 1'b0;
  logic        finish_transmission = 1'b0;
  logic [15:0] data_to_send;
  logic        enable_transmiter;
  logic        sensor_req;
  logic [7:0]  sensor_addr;
  logic        sensor_done = 1'b0;
  logic        sensor_error = 1'b0;
  logic [7:0]  sensor_temp = '0;
  logic [7:0]  sensor_hum = '0;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;
  int n_en  = 0;
  int n_req = 0;

  uart_cmd_dispatcher #(
    .NUM_SENSORS    (c_NUM),
    .TIMEOUT_CYCLES (c_TO),
    .CONT_PERIOD    (c_PER)
  ) dut (
    .clk_9k6             (clk_9k6),
    .rst_n               (rst_n),
    .data_recevied       (data_recevied),
    .data_ready_to_read  (data_ready_to_read),
    .finish_transmission (finish_transmission),
    .data_to_send        (data_to_send),
    .enable_transmiter   (enable_transmiter),
    .sensor_req          (sensor_req),
    .sensor_addr         (sensor_addr),
    .sensor_done         (sensor_done),
    .sensor_error        (sensor_error),
    .sensor_temp         (sensor_temp),
    .sensor_hum          (sensor_hum),
    .overrun             (overrun)
  );

  always #5 clk_9k6 = ~clk_9k6;

  // Pulse counters; at the rising edge outputs still show the last cycle.
  always @(posedge clk_9k6) begin
    if (enable_transmiter) n_en++;
    if (sensor_req)        n_req++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Rx edge lands on the rising edge between the two falling edges.
  task automatic send_word(input logic [15:0] w);
    @(negedge clk_9k6);
    data_recevied      = w;
    data_ready_to_read = 1'b1;
    @(negedge clk_9k6);
    data_ready_to_read = 1'b0;
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    while (!sensor_req && cyc < c_MAX) begin
      @(negedge clk_9k6);
      cyc++;
    end
  endtask

  task automatic wait_en(output int cyc);
    cyc = 0;
    while (!enable_transmiter && cyc < c_MAX) begin
      @(negedge clk_9k6);
      cyc++;
    end
  endtask

  task automatic sensor_reply(input int dly, input logic err,
                              input logic [7:0] t, input logic [7:0] h);
    repeat (dly) @(negedge clk_9k6);
    sensor_done  = 1'b1;
    sensor_error = err;
    sensor_temp  = t;
    sensor_hum   = h;
    @(negedge clk_9k6);
    sensor_done  = 1'b0;
    sensor_error = 1'b0;
  endtask

  task automatic finish_tx();
    @(negedge clk_9k6);
    finish_transmission = 1'b1;
    @(negedge clk_9k6);
    @(negedge clk_9k6);
    finish_transmission = 1'b0;
  endtask

  initial begin
    int cyc;
    int en0;
    int req0;

    // Reset
    repeat (3) @(negedge clk_9k6);
    check("reset_outputs", {5'b0, data_to_send, enable_transmiter, sensor_req, sensor_addr, overrun}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_9k6);

    // Temperature read
    en0 = n_en;
    send_word(16'h0103);
    wait_req(cyc);
    check("temp_req_latency", cyc, 2);
    check("temp_req_addr", sensor_addr, 8'h03);
    sensor_reply(10, 1'b0, 8'h19, 8'h77);
    wait_en(cyc);
    check("temp_data", data_to_send, 16'h0919);
    @(negedge clk_9k6);
    check("temp_en_one_cycle", enable_transmiter, 1'b0);
    finish_tx();
    repeat (2) @(negedge clk_9k6);
    check("temp_back_idle", dut.r_state, ST_IDLE);
    check("temp_en_count", n_en - en0, 1);

    // Unknown command
    req0 = n_req;
    send_word(16'h0720);
    wait_en(cyc);
    check("badcmd_latency", cyc, 2);
    check("badcmd_data", data_to_send, 16'hFF00);
    check("badcmd_no_req", n_req - req0, 0);
    finish_tx();

    // Address out of range
    send_word(16'h0120);
    wait_en(cyc);
    check("badaddr_latency", cyc, 2);
    check("badaddr_data", data_to_send, 16'hFE00);
    finish_tx();

    // Sensor timeout: SENSOR_WAIT lasts c_TO cycles after the request cycle
    send_word(16'h0002);
    wait_req(cyc);
    check("timeout_req_latency", cyc, 2);
    wait_en(cyc);
    check("timeout_cycles", cyc, c_TO + 1);
    check("timeout_data", data_to_send, 16'hFD00);
    finish_tx();

    // Sensor error
    send_word(16'h0002);
    wait_req(cyc);
    sensor_reply(3, 1'b1, 8'h12, 8'h34);
    wait_en(cyc);
    check("senserr_data", data_to_send, 16'h1E00);
    finish_tx();

    // Continuous humidity on address 5
    send_word(16'h0405);
    wait_req(cyc);
    check("cont_req_addr", sensor_addr, 8'h05);
    sensor_reply(2, 1'b0, 8'h11, 8'h30);
    wait_en(cyc);
    check("cont_first_data", data_to_send, 16'h0830);
    finish_tx();
    // IDLE entered on the finish edge, one cycle before finish_tx returns
    wait_req(cyc);
    check("cont_period_1", cyc, c_PER - 1);
    check("cont_addr_1", sensor_addr, 8'h05);
    sensor_reply(2, 1'b0, 8'h11, 8'h31);
    wait_en(cyc);
    check("cont_data_1", data_to_send, 16'h0831);
    finish_tx();
    wait_req(cyc);
    check("cont_period_2", cyc, c_PER - 1);
    sensor_reply(2, 1'b0, 8'h11, 8'h32);
    wait_en(cyc);
    check("cont_data_2", data_to_send, 16'h0832);
    finish_tx();

    // Cancel humidity streaming
    send_word(16'h0600);
    wait_en(cyc);
    check("cancel_latency", cyc, 2);
    check("cancel_data", data_to_send, 16'h0B00);
    finish_tx();
    req0 = n_req;
    repeat (c_PER + 20) @(negedge clk_9k6);
    check("cancel_no_stream", n_req - req0, 0);

    // Cancel when not active
    send_word(16'h0600);
    wait_en(cyc);
    check("cancel_again_data", data_to_send, 16'hFF00);
    finish_tx();

    // Three rx edges during one SENSOR_WAIT
    req0 = n_req;
    send_word(16'h0101);
    wait_req(cyc);
    check("ovr_req_addr", sensor_addr, 8'h01);
    send_word(16'h0202);
    send_word(16'h0103);
    send_word(16'h0104);
    check("ovr_flag_set", overrun, 1'b1);
    sensor_reply(1, 1'b0, 8'h22, 8'h00);
    wait_en(cyc);
    check("ovr_first_data", data_to_send, 16'h0922);
    finish_tx();
    wait_req(cyc);
    check("ovr_second_found", (cyc < c_MAX), 1'b1);
    check("ovr_second_addr", sensor_addr, 8'h02);
    sensor_reply(1, 1'b0, 8'h00, 8'h44);
    wait_en(cyc);
    check("ovr_second_data", data_to_send, 16'h0844);
    finish_tx();
    repeat (10) @(negedge clk_9k6);
    check("ovr_third_dropped", n_req - req0, 2);
    check("ovr_flag_sticky", overrun, 1'b1);

    // Reset during TX_WAIT with continuous mode on and a pending word
    send_word(16'h0307);
    wait_req(cyc);
    sensor_reply(2, 1'b0, 8'h55, 8'h00);
    wait_en(cyc);
    check("rst_pre_data", data_to_send, 16'h0955);
    @(negedge clk_9k6);
    send_word(16'h0101);
    rst_n = 1'b0;
    @(negedge clk_9k6);
    check("rst_mid_outputs", {5'b0, data_to_send, enable_transmiter, sensor_req, sensor_addr, overrun}, 32'h0);
    check("rst_mid_cont_off", dut.r_cont_mode, CONT_OFF);
    check("rst_mid_pend_empty", dut.r_pend_valid, 1'b0);
    rst_n = 1'b1;
    en0  = n_en;
    req0 = n_req;
    repeat (c_PER + 20) @(negedge clk_9k6);
    check("rst_no_tx", n_en - en0, 0);
    check("rst_no_req", n_req - req0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
